// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the multicycle sequencer, the datapath and the
// existing control decoder.
//   OP_*      opcode field values (IR[7:6])
//   state_t   sequencer state encoding (codes 6 and 7 are unused)
//   ALUOP_*   ALU operation select
//   strobes_t bundle of the datapath strobes that depend only on (state, opcode)
package cpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic ALUOP_ADD = 1'b0;
  localparam logic ALUOP_SUB = 1'b1;

  typedef struct packed {
    logic reg_dst;
    logic reg_write;
    logic alu_src;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_op;
  } strobes_t;

endpackage

// File: rtl/mc_strobe_decode.sv
// mc_strobe_decode: purely combinational decode of the datapath strobes from
// the sequencer state and the latched opcode.
//   i_state   current sequencer state
//   i_op      opcode latched in DECODE
//   o_strobes RegDst/RegWrite/ALUsrc/Branch/MemRead/MemWrite/MemtoReg/ALUOp
// PCWrite/IRWrite depend on mem_ready and are produced by the top.
module mc_strobe_decode
  import cpu_pkg::*;
(
  input  state_t     i_state,
  input  logic [1:0] i_op,
  output strobes_t   o_strobes
);

  always_comb begin
    o_strobes = '0;
    case (i_state)
      S_FETCH: o_strobes.mem_read = 1'b1;
      S_EXEC: begin
        case (i_op)
          OP_LW, OP_SW: begin
            o_strobes.alu_src = 1'b1;
            o_strobes.alu_op  = ALUOP_ADD;
          end
          OP_BEQ: begin
            o_strobes.alu_op = ALUOP_SUB;
            o_strobes.branch = 1'b1;
          end
          default: o_strobes.alu_op = ALUOP_ADD;
        endcase
      end
      S_MEM: begin
        o_strobes.mem_read  = (i_op == OP_LW);
        o_strobes.mem_write = (i_op == OP_SW);
      end
      S_WB: begin
        o_strobes.reg_write  = 1'b1;
        o_strobes.reg_dst    = (i_op == OP_ADD);
        o_strobes.mem_to_reg = (i_op == OP_LW);
      end
      default: o_strobes = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle sequencer for the 8-bit CPU datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, stalling in FETCH
// and MEM until mem_ready.
// Ports:
//   clk, reset (async, active-high), start, halt, Instruction[1:0], mem_ready
//   PCWrite, IRWrite (Mealy on mem_ready in FETCH), RegDst, RegWrite, ALUsrc,
//   Branch, MemRead, MemWrite, MemtoReg, ALUOp, state[2:0], instr_count[15:0]
// Build option: MC_INSTR_COUNT_EN builds the retired-instruction counter;
// without it instr_count is tied to 0.
module multicycle_control
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [1:0]  Instruction,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUsrc,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUOp,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic       w_instr_end;
  strobes_t   w_strobes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= Instruction;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_instr_end = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        case (r_op)
          OP_ADD:       w_next = S_WB;
          OP_LW, OP_SW: w_next = S_MEM;
          default:      w_instr_end = 1'b1;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (r_op == OP_LW) w_next = S_WB;
          else               w_instr_end = 1'b1;
        end
      end
      S_WB:     w_instr_end = 1'b1;
      default:  w_next = S_IDLE;
    endcase
    // halt only matters at an instruction boundary
    if (w_instr_end) w_next = halt ? S_IDLE : S_FETCH;
  end

  mc_strobe_decode u_strobe_decode (
    .i_state   (r_state),
    .i_op      (r_op),
    .o_strobes (w_strobes)
  );

  always_comb begin
    PCWrite  = (r_state == S_FETCH) && mem_ready;
    IRWrite  = (r_state == S_FETCH) && mem_ready;
    RegDst   = w_strobes.reg_dst;
    RegWrite = w_strobes.reg_write;
    ALUsrc   = w_strobes.alu_src;
    Branch   = w_strobes.branch;
    MemRead  = w_strobes.mem_read;
    MemWrite = w_strobes.mem_write;
    MemtoReg = w_strobes.mem_to_reg;
    ALUOp    = w_strobes.alu_op;
    state    = r_state;
  end

`ifdef MC_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_instr_count <= 16'd0;
    else if (w_instr_end) r_instr_count <= r_instr_count + 16'd1;
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 16'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt, mem_ready;
  logic [1:0]  Instruction;
  logic        PCWrite, IRWrite, RegDst, RegWrite, ALUsrc, Branch;
  logic        MemRead, MemWrite, MemtoReg, ALUOp;
  logic [2:0]  state;
  logic [15:0] instr_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_cnt  = 16'd0;
  bit          in_idle  = 1'b1;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .Instruction (Instruction),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUsrc      (ALUsrc),
    .Branch      (Branch),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .ALUOp       (ALUOp),
    .state       (state),
    .instr_count (instr_count)
  );

  // {state, PCWrite, IRWrite, RegDst, RegWrite, ALUsrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp}
  wire [12:0] obs_vec = {state, PCWrite, IRWrite, RegDst, RegWrite, ALUsrc,
                         Branch, MemRead, MemWrite, MemtoReg, ALUOp};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Expected outputs for one cycle in phase ph (0 idle,1 fetch,2 decode,3 exec,4 mem,5 wb)
  function automatic logic [12:0] exp_vec(input int ph, input logic [1:0] op, input logic rdy);
    logic pcw, irw, rd, rw, as, br, mr, mw, m2r, ao;
    logic [2:0] s;
    {pcw, irw, rd, rw, as, br, mr, mw, m2r, ao} = '0;
    s = ph[2:0];
    case (ph)
      1: begin mr = 1'b1; pcw = rdy; irw = rdy; end
      3: begin
        if (op == 2'b01 || op == 2'b10) as = 1'b1;
        if (op == 2'b11) begin ao = 1'b1; br = 1'b1; end
      end
      4: begin mr = (op == 2'b01); mw = (op == 2'b10); end
      5: begin rw = 1'b1; rd = (op == 2'b00); m2r = (op == 2'b01); end
      default: ;
    endcase
    return {s, pcw, irw, rd, rw, as, br, mr, mw, m2r, ao};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] rop();
    return 2'($urandom_range(0, 3));
  endfunction

  // One clock cycle: drive inputs just after the edge, check at the falling edge.
  task automatic step(input logic st, input logic hl, input logic [1:0] ins,
                      input logic rdy, input logic [12:0] exp, input string tag);
    start = st; halt = hl; Instruction = ins; mem_ready = rdy;
    @(negedge clk);
    check(tag, {19'b0, obs_vec}, {19'b0, exp});
    check({tag, "_cnt"}, {16'b0, instr_count}, {16'b0, exp_cnt});
    @(posedge clk); #1;
  endtask

  task automatic retire();
`ifdef MC_INSTR_COUNT_EN
    exp_cnt = exp_cnt + 16'd1;
`endif
  endtask

  task automatic enter_fetch();
    if (in_idle) begin
      repeat ($urandom_range(0, 2)) step(1'b0, rbit(), rop(), rbit(), exp_vec(0, 2'b00, 1'b0), "idle");
      step(1'b1, rbit(), rop(), rbit(), exp_vec(0, 2'b00, 1'b0), "idle_start");
      in_idle = 1'b0;
    end
  endtask

  // One whole instruction: fs/ms stall cycles in FETCH/MEM, hlt applied in the final cycle.
  task automatic run_instr(input logic [1:0] op, input int fs, input int ms, input logic hlt);
    logic rdy;
    enter_fetch();
    for (int i = 0; i <= fs; i++) begin
      rdy = (i == fs);
      step(rbit(), rbit(), rop(), rdy, exp_vec(1, op, rdy), "fetch");
    end
    step(rbit(), rbit(), op, rbit(), exp_vec(2, op, 1'b0), "decode");
    step(rbit(), (op == 2'b11) ? hlt : rbit(), rop(), rbit(), exp_vec(3, op, 1'b0), "exec");
    if (op == 2'b01 || op == 2'b10) begin
      for (int i = 0; i <= ms; i++) begin
        rdy = (i == ms);
        step(rbit(), (op == 2'b10 && rdy) ? hlt : rbit(), rop(), rdy, exp_vec(4, op, rdy), "mem");
      end
    end
    if (op == 2'b00 || op == 2'b01)
      step(rbit(), hlt, rop(), rbit(), exp_vec(5, op, 1'b0), "wb");
    retire();
    in_idle = hlt;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; Instruction = 2'b00; mem_ready = 1'b0;
    @(negedge clk);
    check("reset_outputs", {19'b0, obs_vec}, 32'd0);
    check("reset_cnt", {16'b0, instr_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 2'b11, 1'b1, exp_vec(0, 2'b00, 1'b0), "post_reset_idle");

    // directed scenarios
    run_instr(2'b00, 0, 0, 1'b0);   // ADD
    run_instr(2'b01, 2, 3, 1'b0);   // LW with stalls: 10 cycles
    run_instr(2'b10, 0, 0, 1'b0);   // SW
    run_instr(2'b11, 0, 0, 1'b0);   // BEQ
    run_instr(2'b00, 0, 0, 1'b1);   // ADD ending with halt -> IDLE

    // reset while SW waits in MEM
    enter_fetch();
    step(1'b0, 1'b0, 2'b01, 1'b1, exp_vec(1, 2'b10, 1'b1), "rst_fetch");
    step(1'b0, 1'b0, 2'b10, 1'b1, exp_vec(2, 2'b10, 1'b0), "rst_decode");
    step(1'b0, 1'b0, 2'b00, 1'b1, exp_vec(3, 2'b10, 1'b0), "rst_exec");
    mem_ready = 1'b0;
    @(negedge clk);
    check("rst_mem_stall", {19'b0, obs_vec}, {19'b0, exp_vec(4, 2'b10, 1'b0)});
    #2 reset = 1'b1;
    #1;
    check("rst_async_outputs", {19'b0, obs_vec}, 32'd0);
    check("rst_async_cnt", {16'b0, instr_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = 16'd0;
    in_idle = 1'b1;
    run_instr(2'b01, 0, 0, 1'b0);

    // randomized instruction stream
    for (int n = 0; n < 400; n++)
      run_instr(rop(), $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
